// File: rtl/bist_misr.sv
// bist_misr: MISR response compactor with IDLE/RUN/DONE control and golden-signature compare.
// Define BIST_MISR_SIG_OUT_EN to expose the raw signature register on signature_o.
module bist_misr #(
    parameter int              WIDTH  = 3,
    parameter logic [WIDTH-1:0] POLY   = 3'b101,
    parameter logic [WIDTH-1:0] SEED   = '1,
    parameter int              LENGTH = 7,
    parameter logic [WIDTH-1:0] GOLDEN = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] resp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o
`ifdef BIST_MISR_SIG_OUT_EN
   ,output logic [WIDTH-1:0] signature_o
`endif
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d, upd;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pass_q, pass_d;

    // Shift up, fold in the response, and apply the feedback taps when the MSB falls out.
    assign upd = {sig_q[WIDTH-2:0], 1'b0} ^ resp_i
               ^ (sig_q[WIDTH-1] ? {POLY[WIDTH-1:1], 1'b1} : '0);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d = RUN;
                sig_d   = SEED;
                cnt_d   = '0;
                pass_d  = 1'b0;
            end
            RUN: if (abort_i) begin
                state_d = IDLE;
                sig_d   = SEED;
                cnt_d   = '0;
                pass_d  = 1'b0;
            end else if (valid_i) begin
                sig_d = upd;
                if (cnt_q == CW'(LENGTH - 1)) begin
                    state_d = DONE;
                    pass_d  = upd == GOLDEN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy_o = state_q == RUN;
    assign done_o = state_q == DONE;
    assign pass_o = pass_q;
`ifdef BIST_MISR_SIG_OUT_EN
    assign signature_o = sig_q;
`endif
endmodule

// File: tb/tb_bist_misr.sv
// tb_bist_misr: scoreboarded bench for bist_misr (LENGTH=2, GOLDEN=110) with a cycle model.
module tb_bist_misr;
    localparam logic [2:0] POLY   = 3'b101;
    localparam logic [2:0] SEED   = 3'b111;
    localparam logic [2:0] GOLDEN = 3'b110;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, valid = 1'b0;
    logic [2:0] resp = '0;
    logic       busy, done, pass;
`ifdef BIST_MISR_SIG_OUT_EN
    logic [2:0] sig;
`endif

    int         checks = 0, errors = 0;
    int         mst = M_IDLE, mcnt = 0;
    logic [2:0] msig = SEED;
    logic       mpass = 1'b0;
    logic       exp_q[$];

    bist_misr #(.WIDTH(3), .POLY(POLY), .SEED(SEED), .LENGTH(2), .GOLDEN(GOLDEN)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .valid_i(valid), .resp_i(resp), .busy_o(busy), .done_o(done), .pass_o(pass)
`ifdef BIST_MISR_SIG_OUT_EN
       ,.signature_o(sig)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] misr(input logic [2:0] s, input logic [2:0] r);
        logic [2:0] n;
        n[0] = s[2] ^ r[0];
        for (int i = 1; i < 3; i++) n[i] = s[i-1] ^ r[i] ^ (POLY[i] & s[2]);
        return n;
    endfunction

    task automatic model_reset();
        mst = M_IDLE; msig = SEED; mcnt = 0; mpass = 1'b0;
        exp_q.delete();
    endtask

    task automatic tick(input logic s, input logic a, input logic v, input logic [2:0] r);
        logic [2:0] n;
        start = s; abort = a; valid = v; resp = r;
        if (mst != M_RUN) begin
            if (s) begin mst = M_RUN; msig = SEED; mcnt = 0; mpass = 1'b0; end
        end else if (a) begin
            mst = M_IDLE; msig = SEED; mcnt = 0; mpass = 1'b0;
        end else if (v) begin
            n = misr(msig, r);
            msig = n;
            if (mcnt == 1) begin
                mst = M_DONE; mpass = n == GOLDEN;
                exp_q.push_back(n == GOLDEN);
            end else mcnt++;
        end
        @(posedge clk); #1;
        chk("busy", busy, mst == M_RUN);
        chk("done", done, mst == M_DONE);
        chk("pass", pass, mpass);
        if (done && exp_q.size() != 0) chk("verdict", pass, exp_q.pop_front());
`ifdef BIST_MISR_SIG_OUT_EN
        chk("sig", sig, msig);
`endif
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        rst_n = 1'b1;
        tick(0, 0, 1, 3'b101);
        // Clean run: 111 -> 011 -> 110 matches golden
        tick(1, 0, 0, 0); tick(0, 0, 1, 3'b000); tick(0, 0, 1, 3'b000);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        // Restart from DONE, corrupted first word: 111 -> 010 -> 100
        tick(1, 0, 0, 0);
        chk("t2_passclr", pass, 0);
        tick(0, 0, 1, 3'b001); tick(0, 0, 1, 3'b000);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
        // Valid gaps 1,0,0,1 with a stray Start mid-run
        tick(1, 0, 0, 0); tick(0, 0, 1, 0); tick(0, 0, 0, 3'b111); tick(1, 0, 0, 0);
        chk("t3_busy", busy, 1);
        chk("t3_nodone", done, 0);
        tick(0, 0, 1, 0);
        chk("t3_pass", pass, 1);
        tick(0, 1, 0, 0); tick(0, 0, 1, 3'b011);
        chk("t3_hold", done, 1);
        // Abort beats the final Valid
        tick(1, 0, 0, 0); tick(0, 0, 1, 0); tick(0, 1, 1, 0);
        chk("t4_done", done, 0);
        chk("t4_pass", pass, 0);
        chk("t4_busy", busy, 0);
        tick(0, 0, 1, 3'b110); tick(0, 1, 0, 0);
        tick(1, 0, 0, 0); tick(0, 0, 1, 0); tick(0, 0, 1, 0);
        chk("t4_rerun", pass, 1);
        // Reset mid-run after one beat
        tick(1, 0, 0, 0); tick(0, 0, 1, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_pass", pass, 0);
`ifdef BIST_MISR_SIG_OUT_EN
        chk("t5_sig", sig, SEED);
`endif
        #2 rst_n = 1'b1;
        tick(0, 0, 1, 3'b100); tick(0, 0, 0, 0);
        chk("t5_idle", busy, 0);
        tick(1, 0, 0, 0); tick(0, 0, 1, 3'b001); tick(0, 0, 1, 3'b000);
        chk("t5_pass", pass, 0);
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bist_misr.md
# bist_misr

Multiple-input signature register (MISR) with a control FSM: the response-compaction end of the team's BIST chain. It sits downstream of the pattern-generator LFSR and the circuit under test. It folds a fixed number of WIDTH-bit response words into a signature, then compares that signature with a golden value. It reports Done and Pass to the BIST controller.

## Interface
- WIDTH, 3: response and signature width, ≥2
- POLY, 3'b101: feedback polynomial; bit i = coefficient of x^i for i=1..WIDTH-1; bit 0 ignored (x^0 always present); default = 1+x^2+x^3
- SEED, all ones: signature value loaded on Start
- LENGTH, 7: response words compacted per run, ≥1
- GOLDEN, 3'b000: expected final signature
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- Start  in  1  begin a run; sampled in IDLE and DONE only
- Abort  in  1  cancel a run; effective in RUN only
- Valid  in  1  Resp holds a response word this cycle
- Resp  in  WIDTH  response word from circuit under test
- Busy  out  1  high in RUN
- Done  out  1  high in DONE
- Pass  out  1  final signature == GOLDEN; meaningful only while Done=1
- Signature  out  WIDTH  current signature register (present only with BIST_MISR_SIG_OUT_EN)

## Operation
- States: IDLE, RUN, DONE. Two-bit state register; unused encodings return to IDLE.
- Reset (RST=0, asynchronous): state=IDLE, sig=SEED, count=0, Busy=0, Done=0, Pass=0.
- IDLE, Start=1: sig<=SEED, count<=0, go to RUN.
- RUN, Valid=1: sig is updated, with m=sig[WIDTH-1]:
  - sig'[0] = m ^ Resp[0]
  - sig'[i] = sig[i-1] ^ Resp[i] ^ (POLY[i] & m), i=1..WIDTH-1
  - count<=count+1
- RUN, Valid=0: sig and count hold. There is no timeout.
- RUN, Valid=1 and count==LENGTH-1: apply the final update, register Pass <= (sig' == GOLDEN) on the same edge, go to DONE.
- RUN, Abort=1: go to IDLE, sig<=SEED, count<=0, Pass<=0. Abort wins over a simultaneous Valid, including the final beat.
- RUN: Start is ignored.
- DONE: sig and Pass hold. Done stays high until the next Start.
- DONE, Start=1: same as Start in IDLE, i.e. go directly to RUN with sig<=SEED. Pass clears to 0 on that edge.
- Valid in IDLE or DONE is ignored; sig does not change.
- Abort in IDLE or DONE is ignored.
- count width = $clog2(LENGTH+1). count never exceeds LENGTH-1 in RUN.

## Timing
- All outputs are registered and change only on a rising CLK edge, or asynchronously on reset assertion.
- Start at edge k: Busy=1 after edge k. The first compactable Valid is at edge k+1.
- Final Valid beat at edge n: Busy=0, Done=1 and Pass valid, all after edge n. Latency from last response to verdict is 1 cycle.
- Back-to-back runs: Start in DONE at edge k gives Done=0, Busy=1 after edge k.
- With LENGTH=L and Valid continuously high from edge k+1, Done rises after edge k+L.
- Reset asserted mid-run: immediate return to reset values. After release, the block waits in IDLE for Start.

## Configuration
- BIST_MISR_SIG_OUT_EN
  - Defined: Signature port exists and is driven directly from the sig register, which allows golden-value extraction during bring-up.
  - Undefined: port is absent and sig is internal only. Done/Pass behaviour is identical in both builds.

## Test plan
- Default parameters except LENGTH=2, GOLDEN=3'b110; reset, Start, Resp=000,000 with Valid high -> sig 111→011→110, Done=1 and Pass=1 one cycle after the second beat.
- Same setup, Resp=001 then 000 -> sig 111→010→100, Done=1, Pass=0.
- LENGTH=2, Valid gaps: Valid pattern 1,0,0,1 with Resp=000 on valid beats -> same result as the first test; Done rises only after the fourth cycle, and Busy stays high throughout.
- Abort asserted together with the final Valid -> IDLE, Done=0, Pass=0. A following Start reruns from SEED=111.
- Reset asserted mid-run (after one beat) -> Busy=0, Done=0, Pass=0 immediately. With the macro defined, Signature=111.
- Start in DONE, and Start/Valid in IDLE -> DONE restarts with Pass cleared; Valid in IDLE leaves Signature unchanged (checked with BIST_MISR_SIG_OUT_EN).
